// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//
// Receive-side controller between the UART receiver and the APB register block.
// Characters that the receiver completes are buffered in a first-word
// fall-through FIFO, which the register block drains. The block keeps sticky
// overrun and framing-error flags and raises a registered interrupt. Receive
// idle-timeout detection is optional: it is built only when the macro
// UART_RX_TIMEOUT_EN is defined, and otherwise timeout is tied to 0.
//
// Ports
//   PCLK            system clock
//   PRESETn         asynchronous active-low reset
//   rx_data_in      character from the receiver, qualified by rx_ready_in
//   rx_ready_in     1-cycle strobe: character complete, stop bit good
//   frame_error_in  receiver framing-error flag (its rising edge is recorded)
//   rx_busy_in      receiver is mid-frame
//   rx_en           accept characters when 1
//   pop             consume the head entry
//   thresh          interrupt level (0 disables the level interrupt)
//   err_clr         clear the sticky flags
//   rd_data         FIFO head, forced to 0 while the FIFO is empty
//   rd_valid        FIFO non-empty
//   level           entries held, 0..FIFO_DEPTH
//   ovr_err         sticky overrun
//   fe_err          sticky framing error
//   timeout         sticky receive idle timeout
//   irq             combined interrupt, registered

module uart_rx_ctrl #(
    parameter  int DATA_BITS     = 8,
    parameter  int FIFO_DEPTH    = 16,
    parameter  int CLKS_PER_BIT  = 10416,
    parameter  int TIMEOUT_CHARS = 4,
    localparam int AW            = $clog2(FIFO_DEPTH)
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [DATA_BITS-1:0] rx_data_in,
    input  logic                 rx_ready_in,
    input  logic                 frame_error_in,
    input  logic                 rx_busy_in,
    input  logic                 rx_en,
    input  logic                 pop,
    input  logic [AW:0]          thresh,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic [AW:0]          level,
    output logic                 ovr_err,
    output logic                 fe_err,
    output logic                 timeout,
    output logic                 irq
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam int          TLIM     = TIMEOUT_CHARS * 10 * CLKS_PER_BIT;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic                 ovr_q, ovr_d;
    logic                 fe_q, fe_d;
    logic                 fe_in_q;
    logic                 to_q;
    logic                 to_set;
    logic                 irq_q, irq_d;

    logic accept, do_push, do_pop, ovr_set, fe_set;

    assign accept  = rx_ready_in & rx_en;
    assign do_pop  = pop & (level_q != '0);
    // A full FIFO still accepts a character when the head leaves in the same cycle.
    assign do_push = accept & ((level_q != FULL_LVL) | do_pop);
    assign ovr_set = accept & (level_q == FULL_LVL) & ~pop;
    assign fe_set  = frame_error_in & ~fe_in_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        // Set events take priority over a coincident clear.
        ovr_d = ovr_set | (ovr_q & ~err_clr);
        fe_d  = fe_set  | (fe_q  & ~err_clr);
        irq_d = ((thresh != '0) & (level_q >= thresh)) | ovr_q | fe_q | to_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
            fe_in_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovr_q    <= ovr_d;
            fe_q     <= fe_d;
            fe_in_q  <= frame_error_in;
            irq_q    <= irq_d;
        end
    end

    // Storage carries no reset; rd_data masks it while the FIFO is empty.
    always_ff @(posedge PCLK) begin
        if (do_push) mem_q[wr_ptr_q] <= rx_data_in;
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int          CW       = $clog2(TLIM);
    localparam logic [CW-1:0] CNT_LAST = CW'(TLIM - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {T_IDLE, T_COUNT, T_EXPIRED} tstate_e;

    tstate_e       tst_q, tst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_d;
    logic          activity, quiet;

    assign activity = do_push | do_pop;
    // A quiet cycle holds data with no receiver activity and no FIFO traffic.
    // The cycle that leaves T_IDLE is itself the first counted quiet cycle,
    // so the flag rises exactly TLIM quiet cycles after the last activity.
    assign quiet    = (level_q != '0) & ~rx_busy_in & ~activity;

    always_comb begin
        tst_d  = tst_q;
        cnt_d  = cnt_q;
        to_set = 1'b0;
        case (tst_q)
            T_IDLE: begin
                if (quiet) begin
                    tst_d = T_COUNT;
                    cnt_d = CNT_ONE;
                end
            end
            T_COUNT: begin
                if (!quiet) begin
                    tst_d = T_IDLE;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    tst_d  = T_EXPIRED;
                    cnt_d  = '0;
                    to_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            T_EXPIRED: begin
                if (activity | err_clr) tst_d = T_IDLE;
            end
            default: begin
                tst_d = T_IDLE;
                cnt_d = '0;
            end
        endcase
        to_d = to_set | (to_q & ~err_clr);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tst_q <= T_IDLE;
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            tst_q <= tst_d;
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    logic unused_tie;
    assign to_set     = 1'b0;
    assign to_q       = 1'b0;
    assign unused_tie = ^{rx_busy_in, to_set, TLIM[0]};
`endif

    assign rd_valid = (level_q != '0);
    assign level    = level_q;
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign ovr_err  = ovr_q;
    assign fe_err   = fe_q;
    assign timeout  = to_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl. The stimulus process drives directed sequences
// and then randomized traffic. A monitor on the falling clock edge compares
// every output against a reference model: the FIFO is a queue of expected
// characters, and the timeout is modelled as a run of consecutive quiet cycles.
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CPB   = 4;
    localparam int TCH   = 1;
    localparam int TLIM  = TCH * 10 * CPB;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic [DW-1:0] rx_data_in = '0;
    logic          rx_ready_in = 1'b0;
    logic          frame_error_in = 1'b0;
    logic          rx_busy_in = 1'b0;
    logic          rx_en = 1'b0;
    logic          pop = 1'b0;
    logic [AW:0]   thresh = '0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   level;
    logic          ovr_err, fe_err, timeout, irq;

    uart_rx_ctrl #(
        .DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .TIMEOUT_CHARS(TCH)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .rx_data_in(rx_data_in), .rx_ready_in(rx_ready_in),
        .frame_error_in(frame_error_in), .rx_busy_in(rx_busy_in), .rx_en(rx_en), .pop(pop),
        .thresh(thresh), .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .level(level), .ovr_err(ovr_err), .fe_err(fe_err), .timeout(timeout), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    bit m_ovr, m_fe, m_to, m_irq, m_fe_prev, m_exp;
    int qcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: compare the outputs, then advance the model by this cycle's inputs.
    int          lvl;
    logic [DW-1:0] hd;
    bit popv, acc, pushv, ovr_s, fe_s, to_s, quiet, irq_n;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            chk("rst_level",    32'(level),    32'd0);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_data",  32'(rd_data),  32'd0);
            chk("rst_ovr_err",  32'(ovr_err),  32'd0);
            chk("rst_fe_err",   32'(fe_err),   32'd0);
            chk("rst_timeout",  32'(timeout),  32'd0);
            chk("rst_irq",      32'(irq),      32'd0);
            exp_q.delete();
            m_ovr = 0; m_fe = 0; m_to = 0; m_irq = 0; m_fe_prev = 0; m_exp = 0; qcnt = 0;
        end else begin
            lvl = exp_q.size();
            hd  = (lvl != 0) ? exp_q[0] : '0;
            chk("level",    32'(level),    32'(lvl));
            chk("rd_valid", 32'(rd_valid), 32'(lvl != 0));
            chk("rd_data",  32'(rd_data),  32'(hd));
            chk("ovr_err",  32'(ovr_err),  32'(m_ovr));
            chk("fe_err",   32'(fe_err),   32'(m_fe));
            chk("timeout",  32'(timeout),  32'(m_to));
            chk("irq",      32'(irq),      32'(m_irq));

            popv  = pop && (lvl > 0);
            acc   = rx_ready_in && rx_en;
            pushv = acc && ((lvl < DEPTH) || popv);
            ovr_s = acc && (lvl == DEPTH) && !pop;
            fe_s  = frame_error_in && !m_fe_prev;
            irq_n = ((thresh != 0) && (lvl >= int'(thresh))) || m_ovr || m_fe || m_to;

            to_s = 0;
`ifdef UART_RX_TIMEOUT_EN
            quiet = (lvl != 0) && !rx_busy_in && !pushv && !popv;
            if (m_exp) begin
                if (pushv || popv || err_clr) begin
                    m_exp = 0;
                    qcnt  = 0;
                end
            end else if (quiet) begin
                qcnt++;
                if (qcnt == TLIM) begin
                    to_s  = 1;
                    m_exp = 1;
                    qcnt  = 0;
                end
            end else begin
                qcnt = 0;
            end
`endif

            m_ovr     = ovr_s || (m_ovr && !err_clr);
            m_fe      = fe_s  || (m_fe  && !err_clr);
            m_to      = to_s  || (m_to  && !err_clr);
            m_irq     = irq_n;
            m_fe_prev = frame_error_in;
            if (popv)  void'(exp_q.pop_front());
            if (pushv) exp_q.push_back(rx_data_in);
        end
    end

    task automatic cyc(input logic [DW-1:0] d, input bit r, input bit p, input bit c);
        rx_data_in  = d;
        rx_ready_in = r;
        pop         = p;
        err_clr     = c;
        @(posedge PCLK);
        #1;
        rx_ready_in = 1'b0;
        pop         = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        rx_en = 1'b1;

        // Basic ordering and fall-through
        cyc(8'h41, 1, 0, 0); cyc(8'h42, 1, 0, 0); cyc(8'h43, 1, 0, 0);
        idle(2);
        repeat (3) cyc('0, 0, 1, 0);
        cyc('0, 0, 1, 0);            // pop while empty is ignored
        idle(2);

        // Fill, overrun, full push with pop, drain
        for (int i = 0; i < DEPTH; i++) cyc(8'(i * 7 + 1), 1, 0, 0);
        cyc(8'hAA, 1, 0, 0);
        idle(2);
        cyc('0, 0, 0, 1);
        idle(1);
        cyc(8'hAA, 1, 1, 0);
        idle(2);
        repeat (DEPTH) cyc('0, 0, 1, 0);
        idle(2);

        // Receiver disabled: strobes ignored, stored entries still poppable
        cyc(8'h11, 1, 0, 0);
        rx_en = 1'b0;
        cyc(8'h55, 1, 0, 0);
        cyc('0, 0, 1, 0);
        rx_en = 1'b1;
        idle(2);

        // Framing error edge, clear, and clear coincident with a new edge
        cyc(8'h22, 1, 0, 0);
        frame_error_in = 1'b1; idle(2);
        frame_error_in = 1'b0; idle(2);
        cyc('0, 0, 0, 1);
        idle(2);
        frame_error_in = 1'b1; cyc('0, 0, 0, 1);
        frame_error_in = 1'b0; idle(2);
        cyc('0, 0, 1, 1);
        idle(2);

        // Level interrupt
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) cyc(8'(8'h60 + i), 1, 0, 0);
        idle(3);
        cyc(8'h63, 1, 0, 0);
        idle(3);
        cyc('0, 0, 1, 0);
        idle(3);
        repeat (3) cyc('0, 0, 1, 0);
        thresh = '0;
        idle(2);

        // Idle timeout and restart by a pop
        cyc(8'h70, 1, 0, 0);
        idle(TLIM + 5);
        cyc('0, 0, 0, 1);
        cyc('0, 0, 1, 0);
        cyc(8'h71, 1, 0, 0); cyc(8'h72, 1, 0, 0);
        idle(19);
        cyc('0, 0, 1, 0);
        idle(TLIM + 5);
        rx_busy_in = 1'b1; idle(3); rx_busy_in = 1'b0;
        cyc('0, 0, 1, 1);
        idle(2);

        // Reset in the middle of operation
        for (int i = 0; i < 5; i++) cyc(8'(8'h80 + i), 1, 0, 0);
        idle(10);
        PRESETn = 1'b0;
        idle(3);
        PRESETn = 1'b1;
        cyc(8'h90, 1, 0, 0);
        idle(2);

        // Randomized traffic with periodic quiet stretches
        for (int i = 0; i < 3000; i++) begin
            rx_en          = ($urandom_range(0, 19) != 0);
            rx_busy_in     = ($urandom_range(0, 9) == 0);
            frame_error_in = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) thresh = 5'($urandom_range(0, 16));
            if ((i % 600) == 300) begin
                rx_busy_in     = 1'b0;
                frame_error_in = 1'b0;
                rx_en          = 1'b1;
                cyc(8'($urandom), 1, 0, 0);
                idle(TLIM + 10);
            end
            cyc(8'($urandom), $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                $urandom_range(0, 49) == 0);
        end
        rx_busy_in     = 1'b0;
        frame_error_in = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
